// File: rtl/display_pkg.sv
// display_pkg: state encoding and default geometry shared by the display read path.
package display_pkg;
  typedef enum logic [2:0] {IDLE, ARM, LAT, CAP, SEND, DONE} state_t;
  localparam int DISPLAY_DEPTH = 393;
  localparam int MEM_ADDR_W = 11;
endpackage

// File: rtl/display_reader.sv
// display_reader: walks one frame of result RAM via control_unit pulses and streams each word on valid/ready.
// Define DISPLAY_READER_CHECKSUM_EN to accumulate a 16-bit sum of accepted words on checksum.
module display_reader
  import display_pkg::*;
#(
  parameter int DEPTH  = DISPLAY_DEPTH,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic [DATA_W-1:0] RDATA,
  output logic              display,
  output logic              addr_increment,
  output logic              clc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [15:0]       checksum
);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_data;
  logic w_last, w_hs;
  always_comb begin
    w_last = r_idx == ADDR_W'(DEPTH - 1);
    w_hs = r_state == SEND && out_ready;
    display = r_state == ARM;
    addr_increment = w_hs && !w_last;
    clc = r_state == DONE;
    done = r_state == DONE;
    out_valid = r_state == SEND;
    busy = r_state != IDLE;
    case (r_state)
      IDLE: w_next = start ? ARM : IDLE;
      ARM: w_next = LAT;
      LAT: w_next = CAP;
      CAP: w_next = SEND;
      SEND: w_next = !out_ready ? SEND : w_last ? DONE : LAT;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_idx <= '0;
      r_data <= '0;
    end else begin
      r_state <= w_next;
      r_idx <= display ? '0 : addr_increment ? r_idx + 1'b1 : r_idx;
      r_data <= r_state == CAP ? RDATA : r_data;
    end
  end
  assign out_data = r_data;
`ifdef DISPLAY_READER_CHECKSUM_EN
  logic [15:0] r_sum;
  // r_data is the word being accepted, so the sum trails each handshake by one cycle
  always_ff @(posedge CLK)
    r_sum <= (RESET || display) ? '0 : w_hs ? r_sum + 16'(r_data) : r_sum;
  assign checksum = r_sum;
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_display_reader.sv
// tb_display_reader: full-size frames against a control_unit/RAM model plus a DEPTH=4 cycle table.
module tb_display_reader;
`ifdef DISPLAY_READER_CHECKSUM_EN
  localparam bit CKEN = 1'b1;
`else
  localparam bit CKEN = 1'b0;
`endif
  localparam int D = 393;
  logic CLK = 1'b0, RESET = 1'b1;
  logic start = 1'b0, out_ready = 1'b0, display, addr_inc, clc, out_valid, busy, done;
  logic [7:0] rdata, data;
  logic [15:0] cks;
  logic [10:0] addr;
  logic [7:0] ram [0:D-1];
  logic s_start = 1'b0, s_ready = 1'b0, s_display, s_inc, s_clc, s_valid, s_busy, s_done;
  logic [7:0] s_rdata, s_data;
  logic [15:0] s_cks;
  logic [1:0] s_addr;
  logic [7:0] sram [0:3];
  int cyc = 0, checks = 0, errors = 0, inv_err = 0;
  bit m_busy, prev_hold;
  logic [7:0] prev_data;

  always #5 CLK = ~CLK;

  display_reader #(.DEPTH(D), .ADDR_W(11), .DATA_W(8)) u_big (
    .CLK(CLK), .RESET(RESET), .start(start), .RDATA(rdata), .display(display),
    .addr_increment(addr_inc), .clc(clc), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(data), .busy(busy), .done(done), .checksum(cks));

  display_reader #(.DEPTH(4), .ADDR_W(2), .DATA_W(8)) u_small (
    .CLK(CLK), .RESET(RESET), .start(s_start), .RDATA(s_rdata), .display(s_display),
    .addr_increment(s_inc), .clc(s_clc), .out_valid(s_valid), .out_ready(s_ready),
    .out_data(s_data), .busy(s_busy), .done(s_done), .checksum(s_cks));

  // control_unit address pointer and 1-cycle synchronous RAM for each instance
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    addr <= (RESET || display) ? 11'd0 : addr_inc ? addr + 11'd1 : addr;
    rdata <= addr < D ? ram[addr] : 8'h00;
    s_addr <= (RESET || s_display) ? 2'd0 : s_inc ? s_addr + 2'd1 : s_addr;
    s_rdata <= sram[s_addr];
    m_busy <= RESET ? 1'b0 : (!m_busy && start) ? 1'b1 : clc ? 1'b0 : m_busy;
    prev_hold <= !RESET && out_valid && !out_ready;
    prev_data <= data;
  end

  always @(negedge CLK) begin
    if (int'(display) + int'(addr_inc) + int'(clc) > 1) inv_err++;
    if (int'(s_display) + int'(s_inc) + int'(s_clc) > 1) inv_err++;
    if (done !== clc || s_done !== s_clc || busy !== m_busy) inv_err++;
    if (prev_hold && (out_valid !== 1'b1 || data !== prev_data)) inv_err++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // mode 0: always ready, 1: stall 5 cycles on word 10, 2: random ready
  task automatic frame(input int mode, input bit poke, input int abort_at);
    int t, hs, incs, stalls, first_v, disp_c, stall_left, exp;
    bit got_clc, aborted;
    logic [15:0] sum;
    hs = 0; incs = 0; stalls = 0; first_v = -1; disp_c = -1; stall_left = 5;
    got_clc = 0; aborted = 0; sum = 0;
    @(posedge CLK); #1 start = 1'b1; out_ready = 1'b1;
    t = cyc;
    for (int n = 0; n < 6000 && !got_clc && !aborted; n++) begin
      @(posedge CLK); #1;
      start = poke && out_valid && hs == 3;
      if (abort_at >= 0 && out_valid && hs == abort_at) begin
        RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0;
        @(negedge CLK);
        chk("reset mid-frame outputs", {display, addr_inc, clc, out_valid, busy, done, data, cks}, 0);
        aborted = 1'b1;
      end else begin
        out_ready = mode == 0 ? 1'b1 : mode == 2 ? ($urandom_range(0, 2) != 0)
                  : !(out_valid && hs == 10 && stall_left > 0);
        if (mode == 1 && !out_ready) stall_left--;
        @(negedge CLK);
        if (display) disp_c = cyc;
        if (addr_inc) incs++;
        if (out_valid && first_v < 0) first_v = cyc;
        if (out_valid && !out_ready) begin
          stalls++;
          if (mode == 1) begin
            chk("stall data", data, ram[10]);
            chk("stall no addr_increment", addr_inc, 0);
          end
        end
        if (out_valid && out_ready) begin
          exp = hs < D ? int'(ram[hs]) : 256;
          chk($sformatf("word %0d", hs), data, exp);
          sum += 16'(data);
          hs++;
        end
        if (clc) begin
          got_clc = 1'b1;
          chk("clc cycle", cyc, t + 2 + 3 * D + stalls);
          chk("checksum at done", cks, CKEN ? sum : 16'h0);
        end
      end
    end
    if (!aborted) begin
      chk("clc seen", got_clc, 1);
      chk("word count", hs, D);
      chk("addr_increment count", incs, D - 1);
      chk("display cycle", disp_c, t + 1);
      chk("first valid cycle", first_v, t + 4);
    end
  endtask

  typedef struct packed {
    logic st;
    logic rdy;
    logic [4:0] f;
    logic [7:0] d;
    logic [15:0] c;
  } vec_t;
  vec_t tv [18];

  initial begin
    // flags: {display, addr_increment, clc, out_valid, busy}
    tv[0]  = {1'b1, 1'b0, 5'b00000, 8'h00, 16'h0000};
    tv[1]  = {1'b0, 1'b0, 5'b10001, 8'h00, 16'h0000};
    tv[2]  = {1'b0, 1'b0, 5'b00001, 8'h00, 16'h0000};
    tv[3]  = {1'b0, 1'b0, 5'b00001, 8'h00, 16'h0000};
    tv[4]  = {1'b0, 1'b0, 5'b00011, 8'h10, 16'h0000};
    tv[5]  = {1'b0, 1'b1, 5'b01011, 8'h10, 16'h0000};
    tv[6]  = {1'b0, 1'b1, 5'b00001, 8'h10, 16'h0010};
    tv[7]  = {1'b0, 1'b1, 5'b00001, 8'h10, 16'h0010};
    tv[8]  = {1'b1, 1'b1, 5'b01011, 8'h20, 16'h0010};
    tv[9]  = {1'b0, 1'b1, 5'b00001, 8'h20, 16'h0030};
    tv[10] = {1'b0, 1'b1, 5'b00001, 8'h20, 16'h0030};
    tv[11] = {1'b0, 1'b1, 5'b01011, 8'h30, 16'h0030};
    tv[12] = {1'b0, 1'b1, 5'b00001, 8'h30, 16'h0060};
    tv[13] = {1'b0, 1'b1, 5'b00001, 8'h30, 16'h0060};
    tv[14] = {1'b0, 1'b1, 5'b00011, 8'hF0, 16'h0060};
    tv[15] = {1'b0, 1'b1, 5'b00101, 8'hF0, 16'h0150};
    tv[16] = {1'b0, 1'b0, 5'b00000, 8'hF0, 16'h0150};
    tv[17] = {1'b0, 1'b0, 5'b00000, 8'hF0, 16'h0150};
    sram[0] = 8'h10; sram[1] = 8'h20; sram[2] = 8'h30; sram[3] = 8'hF0;
    for (int i = 0; i < D; i++) ram[i] = 8'(i % 256);
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    chk("reset outputs", {display, addr_inc, clc, out_valid, busy, done, data, cks}, 0);
    for (int i = 0; i < 18; i++) begin
      @(posedge CLK); #1 s_start = tv[i].st; s_ready = tv[i].rdy;
      @(negedge CLK);
      chk($sformatf("small row%0d flags", i), {s_display, s_inc, s_clc, s_valid, s_busy}, tv[i].f);
      chk($sformatf("small row%0d data", i), s_data, tv[i].d);
      chk($sformatf("small row%0d checksum", i), s_cks, CKEN ? tv[i].c : 16'h0);
    end
    frame(0, 1'b0, -1);
    frame(0, 1'b0, -1);
    frame(1, 1'b0, -1);
    frame(0, 1'b1, -1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("start in SEND not queued", busy, 0);
    frame(0, 1'b0, 100);
    frame(0, 1'b0, -1);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < D; i++) ram[i] = 8'($urandom_range(0, 255));
      frame(2, 1'b0, -1);
    end
    @(negedge CLK);
    chk("invariants", inv_err, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
